guess_scorer: RTL and testbench

GUESS_SCORER -- requirements
Module: guess_scorer

---
 rtl/guess_scorer_pkg.sv | 23 ++
 rtl/guess_scorer_fb_sorter.sv | 27 ++
 rtl/guess_scorer.sv | 155 +++++++++++++++
 tb/tb_guess_scorer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/guess_scorer_pkg.sv
// Shared types and constants for the guess scorer: colour width, FSM states
// and per-peg feedback codes.
package guess_scorer_pkg;

  localparam int unsigned COLOR_W = 3;
  localparam int unsigned PEGS    = 4;
  localparam int unsigned FB_W    = 2;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned TURNS_W = 4;
  localparam int unsigned PAIR_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXACT = 2'd1,
    PAIR  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [FB_W-1:0] FB_NONE    = 2'd0;
  localparam logic [FB_W-1:0] FB_PARTIAL = 2'd1;
  localparam logic [FB_W-1:0] FB_EXACT   = 2'd2;

endpackage

// File: rtl/guess_scorer_fb_sorter.sv
// Maps exact/partial counts to sorted peg feedback: ssd3 downward shows the
// exact pegs, then the colour-only pegs, then empty pegs.
module fb_sorter
  import guess_scorer_pkg::*;
(
  input  logic [CNT_W-1:0]           exact_cnt,
  input  logic [CNT_W-1:0]           partial_cnt,
  output logic [PEGS-1:0][FB_W-1:0]  ssd_c
);

  logic [CNT_W:0] total_c;

  always_comb begin
    ssd_c   = '0;
    total_c = (CNT_W+1)'(exact_cnt) + (CNT_W+1)'(partial_cnt);
    for (int p = 0; p < int'(PEGS); p++) begin
      // rank 0 is the leftmost peg (ssd3)
      if (CNT_W'(int'(PEGS) - 1 - p) < exact_cnt)
        ssd_c[p] = FB_EXACT;
      else if ((CNT_W+1)'(int'(PEGS) - 1 - p) < total_c)
        ssd_c[p] = FB_PARTIAL;
      else
        ssd_c[p] = FB_NONE;
    end
  end

endmodule

// File: rtl/guess_scorer.sv
// Mastermind-style scorer: latches a guess and the secret code, counts exact
// matches in one cycle, then sweeps all 16 guess/code pairs for colour-only hits.
module guess_scorer
  import guess_scorer_pkg::*;
#(
  parameter int unsigned MAX_TURNS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic [COLOR_W-1:0] code0,
  input  logic [COLOR_W-1:0] code1,
  input  logic [COLOR_W-1:0] code2,
  input  logic [COLOR_W-1:0] code3,
  input  logic [COLOR_W-1:0] history0,
  input  logic [COLOR_W-1:0] history1,
  input  logic [COLOR_W-1:0] history2,
  input  logic [COLOR_W-1:0] history3,
  output logic [FB_W-1:0]    ssd0,
  output logic [FB_W-1:0]    ssd1,
  output logic [FB_W-1:0]    ssd2,
  output logic [FB_W-1:0]    ssd3,
  output logic [CNT_W-1:0]   exact_cnt,
  output logic [CNT_W-1:0]   partial_cnt,
  output logic               busy,
  output logic               done,
  output logic [TURNS_W-1:0] turns,
  output logic               win,
  output logic               game_over
);

  state_t                          state;
  logic [PEGS-1:0][COLOR_W-1:0]    code_q;
  logic [PEGS-1:0][COLOR_W-1:0]    guess_q;
  logic [PEGS-1:0]                 code_used;
  logic [PEGS-1:0]                 guess_used;
  logic [CNT_W-1:0]                exact_int;
  logic [CNT_W-1:0]                partial_int;
  logic [PAIR_W-1:0]               pair_idx;
  logic [PEGS-1:0][FB_W-1:0]       ssd_q;

  logic [PEGS-1:0]                 exact_mask_c;
  logic [CNT_W-1:0]                exact_sum_c;
  logic [1:0]                      pi_c;
  logic [1:0]                      pj_c;
  logic                            pair_hit_c;
  logic [TURNS_W-1:0]              turns_inc_c;
  logic [PEGS-1:0][FB_W-1:0]       sorted_c;

  always_comb begin
    exact_sum_c = '0;
    for (int i = 0; i < int'(PEGS); i++) begin
      exact_mask_c[i] = (guess_q[i] == code_q[i]);
      exact_sum_c     = exact_sum_c + CNT_W'(exact_mask_c[i]);
    end
  end

  // Pair sweep: guess index outer, code index inner
  assign pi_c       = pair_idx[3:2];
  assign pj_c       = pair_idx[1:0];
  assign pair_hit_c = !guess_used[pi_c] && !code_used[pj_c] &&
                      (guess_q[pi_c] == code_q[pj_c]);

  assign turns_inc_c = (turns == TURNS_W'(MAX_TURNS)) ? turns : turns + TURNS_W'(1);

  fb_sorter u_fb_sorter (
    .exact_cnt   (exact_int),
    .partial_cnt (partial_int),
    .ssd_c       (sorted_c)
  );

  assign ssd0 = ssd_q[0];
  assign ssd1 = ssd_q[1];
  assign ssd2 = ssd_q[2];
  assign ssd3 = ssd_q[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      code_q      <= '0;
      guess_q     <= '0;
      code_used   <= '0;
      guess_used  <= '0;
      exact_int   <= '0;
      partial_int <= '0;
      pair_idx    <= '0;
      ssd_q       <= '0;
      exact_cnt   <= '0;
      partial_cnt <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      turns       <= '0;
      win         <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state       <= IDLE;
        busy        <= 1'b0;
        turns       <= '0;
        win         <= 1'b0;
        game_over   <= 1'b0;
        exact_cnt   <= '0;
        partial_cnt <= '0;
        ssd_q       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !game_over) begin
              code_q      <= {code3, code2, code1, code0};
              guess_q     <= {history3, history2, history1, history0};
              code_used   <= '0;
              guess_used  <= '0;
              exact_int   <= '0;
              partial_int <= '0;
              busy        <= 1'b1;
              state       <= EXACT;
            end
          end
          EXACT: begin
            guess_used <= exact_mask_c;
            code_used  <= exact_mask_c;
            exact_int  <= exact_sum_c;
            pair_idx   <= '0;
            state      <= PAIR;
          end
          PAIR: begin
            if (pair_hit_c) begin
              guess_used[pi_c] <= 1'b1;
              code_used[pj_c]  <= 1'b1;
              partial_int      <= partial_int + CNT_W'(1);
            end
            pair_idx <= pair_idx + PAIR_W'(1);
            if (pair_idx == PAIR_W'(15)) state <= DONE;
          end
          DONE: begin
            exact_cnt   <= exact_int;
            partial_cnt <= partial_int;
            ssd_q       <= sorted_c;
            done        <= 1'b1;
            busy        <= 1'b0;
            turns       <= turns_inc_c;
            if (exact_int == CNT_W'(PEGS)) win <= 1'b1;
            if ((exact_int == CNT_W'(PEGS)) || (turns_inc_c == TURNS_W'(MAX_TURNS)))
              game_over <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_guess_scorer.sv
// Directed bench for guess_scorer: latency, scoring patterns, game end,
// clear/reset aborts.
module tb_guess_scorer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, clear;
  logic [2:0] code0, code1, code2, code3;
  logic [2:0] history0, history1, history2, history3;
  logic [1:0] ssd0, ssd1, ssd2, ssd3;
  logic [2:0] exact_cnt, partial_cnt;
  logic       busy, done;
  logic [3:0] turns;
  logic       win, game_over;

  int checks = 0;
  int errors = 0;

  guess_scorer #(.MAX_TURNS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .code0(code0), .code1(code1), .code2(code2), .code3(code3),
    .history0(history0), .history1(history1), .history2(history2), .history3(history3),
    .ssd0(ssd0), .ssd1(ssd1), .ssd2(ssd2), .ssd3(ssd3),
    .exact_cnt(exact_cnt), .partial_cnt(partial_cnt),
    .busy(busy), .done(done), .turns(turns), .win(win), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full result snapshot; ssd packed as {ssd3,ssd2,ssd1,ssd0}
  task automatic check_res(input string tag, input int ex, input int pa,
                           input logic [7:0] ssd, input bit w, input bit go, input int t);
    check({tag, ".exact"},   32'(exact_cnt), 32'(ex));
    check({tag, ".partial"}, 32'(partial_cnt), 32'(pa));
    check({tag, ".ssd"},     32'({ssd3, ssd2, ssd1, ssd0}), 32'(ssd));
    check({tag, ".win"},     32'(win), 32'(w));
    check({tag, ".over"},    32'(game_over), 32'(go));
    check({tag, ".turns"},   32'(turns), 32'(t));
  endtask

  task automatic set_io(input int c0, c1, c2, c3, g0, g1, g2, g3);
    code0 = 3'(c0); code1 = 3'(c1); code2 = 3'(c2); code3 = 3'(c3);
    history0 = 3'(g0); history1 = 3'(g1); history2 = 3'(g2); history3 = 3'(g3);
  endtask

  // Runs one scoring with timing checks; inputs are scrambled while busy
  task automatic score(input string tag, input int c0, c1, c2, c3, g0, g1, g2, g3,
                       input bit rel_rst);
    @(negedge clk);
    if (rel_rst) rst_n = 1'b1;
    set_io(c0, c1, c2, c3, g0, g1, g2, g3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_n"}, 32'(busy), 32'd1);
    set_io(7 - c0, 7 - c1, 7 - c2, 7 - c3, 7 - g3, 7 - g2, 7 - g1, 7 - g0);
    repeat (17) @(posedge clk);
    #1;
    check({tag, ".busy_n17"}, 32'(busy), 32'd1);
    check({tag, ".done_n17"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    check({tag, ".done_n18"}, 32'(done), 32'd1);
    check({tag, ".busy_n18"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  // Watches for any busy/done activity over n cycles
  task automatic expect_quiet(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (busy || done) seen++;
    end
    check({tag, ".quiet"}, 32'(seen), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    set_io(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_res("reset", 0, 0, 8'h00, 0, 0, 0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Reversed guess: all colour-only
    score("rev", 1, 2, 3, 4, 4, 3, 2, 1, 1'b0);
    check_res("rev", 0, 4, 8'b01_01_01_01, 0, 0, 1);

    // Duplicate colours credited once
    score("dup", 1, 1, 2, 2, 1, 2, 1, 1, 1'b0);
    check_res("dup", 1, 2, 8'b10_01_01_00, 0, 0, 2);

    // Reset mid-scoring discards the result
    @(negedge clk);
    set_io(1, 2, 3, 4, 1, 2, 3, 4);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_res("rst_mid", 0, 0, 8'h00, 0, 0, 0);
    check("rst_mid.busy", 32'(busy), 32'd0);
    repeat (20) begin
      @(posedge clk); #1;
      if (done) check("rst_mid.no_done", 32'(done), 32'd0);
    end

    // Start accepted on the first edge after reset release
    score("post_rst", 1, 2, 3, 4, 1, 2, 4, 3, 1'b1);
    check_res("post_rst", 2, 2, 8'b10_10_01_01, 0, 0, 1);

    // Restart mid-scoring is ignored; clear at N+10 aborts
    @(negedge clk);
    set_io(1, 2, 3, 4, 1, 2, 3, 4);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check_res("abort", 0, 0, 8'h00, 0, 0, 0);
    expect_quiet("abort", 25);

    // Clear wins over simultaneous start
    @(negedge clk);
    clear = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0;
    check("clr_start.busy", 32'(busy), 32'd0);
    expect_quiet("clr_start", 20);

    // Winning guess ends the game
    score("win", 1, 2, 3, 4, 1, 2, 3, 4, 1'b0);
    check_res("win", 4, 0, 8'b10_10_10_10, 1, 1, 1);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("win_ignore.busy", 32'(busy), 32'd0);
    expect_quiet("win_ignore", 20);
    check_res("win_hold", 4, 0, 8'b10_10_10_10, 1, 1, 1);

    @(negedge clk) clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_res("clr_win", 0, 0, 8'h00, 0, 0, 0);

    // Eight losing guesses exhaust the game
    score("lose1", 5, 0, 0, 0, 6, 5, 5, 5, 1'b0);
    check_res("lose1", 0, 1, 8'b01_00_00_00, 0, 0, 1);
    for (int k = 2; k <= 8; k++) begin
      score($sformatf("lose%0d", k), 0, 0, 0, 0, 7, 7, 7, 7, 1'b0);
      check_res($sformatf("lose%0d", k), 0, 0, 8'h00, 0, (k == 8), k);
    end
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("over_ignore.busy", 32'(busy), 32'd0);
    expect_quiet("over_ignore", 22);
    check("over_ignore.turns", 32'(turns), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
